// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in/serial-out front end with one-word holding buffer
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_start,
  output logic             word_last
);

  localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   r_sr;
  logic [WIDTH-1:0]   r_hr;
  logic               r_occ;
  logic               r_hf;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_accept;
  logic               w_consume;
  logic               w_last;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_head;

  assign din_ready = !r_hf && !rst;
  assign w_accept  = din_valid && din_ready;
  assign w_consume = r_occ && shift_en;
  assign w_last    = w_consume && (r_cnt == c_LAST);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_sr[WIDTH-2:0], 1'b0};
      assign w_head    = r_sr[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, r_sr[WIDTH-1:1]};
      assign w_head    = r_sr[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_hr  <= '0;
      r_occ <= 1'b0;
      r_hf  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_consume) begin
        if (w_last) begin
          r_cnt <= '0;
          if (r_hf) begin
            r_sr <= r_hr;
            r_hf <= 1'b0;
          end else begin
            r_occ <= 1'b0;
          end
        end else begin
          r_sr  <= w_shifted;
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
      // An accept implies HF=0, so a last-bit consume here frees SR for din.
      if (w_accept) begin
        if (!r_occ || w_last) begin
          r_sr  <= din;
          r_occ <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_hr <= din;
          r_hf <= 1'b1;
        end
      end
    end
  end

  assign sout_valid = r_occ;
  assign sout       = r_occ & w_head;
  assign word_start = r_occ && (r_cnt == '0);
  assign word_last  = r_occ && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// Directed bench for piso_serializer: MSB-first and LSB-first instances share
// one stimulus stream; checks are sampled on the falling edge.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       shift_en;

  logic din_ready, sout, sout_valid, word_start, word_last;
  logic din_ready_l, sout_l, sout_valid_l, word_start_l, word_last_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .shift_en(shift_en), .sout(sout),
    .sout_valid(sout_valid), .word_start(word_start), .word_last(word_last)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_l), .shift_en(shift_en), .sout(sout_l),
    .sout_valid(sout_valid_l), .word_start(word_start_l), .word_last(word_last_l)
  );

  task automatic test_reset();
    rst = 1'b1; din = 8'hFF; din_valid = 1'b1; shift_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({sout_valid, sout, din_ready, word_start, word_last} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d: got v=%b s=%b rdy=%b ws=%b wl=%b, want all 0",
                 c, sout_valid, sout, din_ready, word_start, word_last);
      end
      n_cmp++;
      if ({sout_valid_l, din_ready_l} !== 2'b0) begin
        n_err++;
        $display("FAIL reset_outputs_lsb cyc%0d: got v=%b rdy=%b, want 0 0",
                 c, sout_valid_l, din_ready_l);
      end
    end
    rst = 1'b0; din_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (din_ready !== 1'b1 || sout_valid !== 1'b0 || sout !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release cyc%0d: got rdy=%b v=%b s=%b, want rdy=1 v=0 s=0",
                 c, din_ready, sout_valid, sout);
      end
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_bits = 8'hB5;
    din = 8'hB5; din_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (sout_valid !== 1'b1 || sout !== exp_bits[7-i] ||
          word_start !== (i == 0) || word_last !== (i == 7)) begin
        n_err++;
        $display("FAIL single_bit%0d: got v=%b s=%b ws=%b wl=%b, want v=1 s=%b ws=%b wl=%b",
                 i, sout_valid, sout, word_start, word_last,
                 exp_bits[7-i], (i == 0), (i == 7));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sout_valid !== 1'b0 || sout !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: got v=%b s=%b, want v=0 s=0", sout_valid, sout);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_bits = 16'b1101000000001101;
    din = 8'hD0; din_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    din = 8'h0D;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) din_valid = 1'b0;
      n_cmp++;
      if (sout_valid !== 1'b1 || sout !== exp_bits[15-i] ||
          word_start !== (i == 0 || i == 8) || word_last !== (i == 7 || i == 15)) begin
        n_err++;
        $display("FAIL b2b_bit%0d: got v=%b s=%b ws=%b wl=%b, want v=1 s=%b ws=%b wl=%b",
                 i, sout_valid, sout, word_start, word_last, exp_bits[15-i],
                 (i == 0 || i == 8), (i == 7 || i == 15));
      end
      n_cmp++;
      if (din_ready !== !(i >= 1 && i <= 7)) begin
        n_err++;
        $display("FAIL b2b_ready%0d: got %b, want %b", i, din_ready, !(i >= 1 && i <= 7));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: got v=%b, want 0", sout_valid);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_a = 8'hB5;
    logic [7:0] exp_b = 8'h0F;
    din = 8'hB5; din_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        shift_en = 1'b0; din = 8'h0F; din_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
          n_cmp++;
          if (sout_valid !== 1'b1 || sout !== exp_a[4] || word_start !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold%0d: got v=%b s=%b ws=%b, want v=1 s=%b ws=0",
                     s, sout_valid, sout, word_start, exp_a[4]);
          end
          if (s == 1) begin
            din_valid = 1'b0;
            n_cmp++;
            if (din_ready !== 1'b0) begin
              n_err++;
              $display("FAIL stall_hr_full: got rdy=%b, want 0", din_ready);
            end
          end
          if (s == 3) shift_en = 1'b1;
          @(negedge clk);
        end
      end else begin
        n_cmp++;
        if (sout_valid !== 1'b1 || sout !== exp_a[7-i] || word_last !== (i == 7)) begin
          n_err++;
          $display("FAIL stall_bit%0d: got v=%b s=%b wl=%b, want v=1 s=%b wl=%b",
                   i, sout_valid, sout, word_last, exp_a[7-i], (i == 7));
        end
        @(negedge clk);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (sout_valid !== 1'b1 || sout !== exp_b[7-i] || word_start !== (i == 0)) begin
        n_err++;
        $display("FAIL stall_next_bit%0d: got v=%b s=%b ws=%b, want v=1 s=%b ws=%b",
                 i, sout_valid, sout, word_start, exp_b[7-i], (i == 0));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_idle: got v=%b, want 0", sout_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] exp_bits = 8'h81;
    din = 8'hB5; din_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    din = 8'h0F;
    @(negedge clk);
    din_valid = 1'b0;
    n_cmp++;
    if (din_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_hr_full: got rdy=%b, want 0", din_ready);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (sout_valid !== 1'b0 || sout !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b s=%b, want 0 0", sout_valid, sout);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (sout_valid !== 1'b0 || din_ready !== 1'b1) begin
        n_err++;
        $display("FAIL mid_lost%0d: got v=%b rdy=%b, want v=0 rdy=1", c, sout_valid, din_ready);
      end
    end
    din = 8'h81; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (sout_valid !== 1'b1 || sout !== exp_bits[7-i] || word_start !== (i == 0)) begin
        n_err++;
        $display("FAIL mid_new_bit%0d: got v=%b s=%b ws=%b, want v=1 s=%b ws=%b",
                 i, sout_valid, sout, word_start, exp_bits[7-i], (i == 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lsb_order();
    logic [7:0] exp_seq = 8'b10101101;
    din = 8'hB5; din_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (sout_valid_l !== 1'b1 || sout_l !== exp_seq[7-i] ||
          word_start_l !== (i == 0) || word_last_l !== (i == 7)) begin
        n_err++;
        $display("FAIL lsb_bit%0d: got v=%b s=%b ws=%b wl=%b, want v=1 s=%b ws=%b wl=%b",
                 i, sout_valid_l, sout_l, word_start_l, word_last_l,
                 exp_seq[7-i], (i == 0), (i == 7));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sout_valid_l !== 1'b0) begin
      n_err++;
      $display("FAIL lsb_idle: got v=%b, want 0", sout_valid_l);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_lsb_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out front end for the FSM pattern-detector stages. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per cycle on a serial line that drives a detector's serial data input. A one-word holding buffer lets back-to-back words stream with no idle cycle between them. A shift-enable input lets the consumer stall the stream.

## Interface
- WIDTH, 8: word width in bits, ≥2.
- MSB_FIRST, 1: 1 emits bit WIDTH-1 first; 0 emits bit 0 first.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  parallel word.
- din_valid  in  1  din holds a word to send.
- din_ready  out  1  block can accept a word this cycle.
- shift_en  in  1  consumer takes the current serial bit this cycle.
- sout  out  1  current serial bit; 0 whenever sout_valid=0.
- sout_valid  out  1  sout carries a word bit.
- word_start  out  1  sout is bit 0 of the emission order of a word.
- word_last  out  1  sout is the final bit of a word.

## Operation
- Storage:
  - shift register SR (WIDTH) with occupied flag;
  - bit counter CNT (clog2(WIDTH) bits, 0..WIDTH-1);
  - holding register HR (WIDTH) with full flag HF.
- Handshake:
  - din_ready = !HF && !rst.
  - A word is accepted at an edge where din_valid && din_ready.
  - din is don't-care otherwise.
- Consume: a bit is consumed at an edge where sout_valid && shift_en. SR then shifts by one (left if MSB_FIRST, else right) and CNT increments.
- Last-bit consume (CNT=WIDTH-1):
  - if HF, HR moves into SR, CNT=0, HF clears, giving a gapless next word;
  - else SR becomes empty.
- Word routing on accept:
  - if SR is empty, or SR is emptying this edge with HF=0, the word loads directly into SR (CNT=0);
  - otherwise the word goes to HR and HF sets.
- Simultaneous last-bit consume with HF=1: no accept is possible that cycle because din_ready=0. HR→SR transfer only.
- shift_en=0: SR, CNT and sout hold. Accepts still proceed per the routing rules (fill SR if empty, else HR).
- Outputs, combinational from registers:
  - sout_valid = SR occupied;
  - sout = emitting end of SR, gated by sout_valid;
  - word_start = sout_valid && CNT==0;
  - word_last = sout_valid && CNT==WIDTH-1.
- Reset: clears SR, CNT, HR, HF and the occupied flag. A partially sent word and any held word are discarded. Inputs are ignored while rst=1.

## Timing
- Reset values, during rst and the cycle after release:
  - sout=0, sout_valid=0, word_start=0, word_last=0;
  - din_ready=0 while rst=1, and 1 in the first cycle after release.
- Latency: a word accepted at edge k into an empty block has its first bit on sout (sout_valid=1) in the cycle after edge k.
- With shift_en held at 1, a word occupies exactly WIDTH consecutive cycles. A second word accepted before the first one's last bit is consumed follows with zero gap.
- Stalls stretch the current bit. No bit is dropped or duplicated.
- din_ready deasserts the cycle after a word lands in HR. It reasserts the cycle after HR moves into SR.

## Test plan
- Reset: rst=1 for 2 cycles with din_valid=1, din=8'hFF → sout_valid=0, sout=0, din_ready=0 throughout. din_ready=1 the first cycle after release, and no word is emitted.
- Single word: MSB_FIRST=1, 8'hB5 accepted at edge k, shift_en=1 → sout = 1,0,1,1,0,1,0,1 over cycles k+1..k+8.
  - word_start only with the first bit, word_last only with the eighth.
  - sout_valid=0 from cycle k+9.
- Back-to-back: 8'hD0 then 8'h0D with din_valid held high → 16 contiguous valid bits 1101000000001101.
  - din_ready low while HR is full.
  - word_start at bits 0 and 8, word_last at bits 7 and 15.
- Stall: 8'hB5 with shift_en=0 for 3 cycles while bit index 3 is on sout → that bit (1) stays on sout for 4 cycles. The full sequence is unchanged and a word accepted during the stall lands in HR.
- Reset mid-stream: rst for one cycle after 4 bits of 8'hB5, with 8'h0F held in HR → sout_valid=0 the next cycle and both words are lost. A subsequent 8'h81 emits 1,0,0,0,0,0,0,1 from bit 0.
- LSB order: MSB_FIRST=0, 8'hB5 → sout = 1,0,1,0,1,1,0,1, with word_start and word_last as in the single-word case.
